// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: state encoding,
// default register-address width and the mult/div counter width helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    HALTED  = 2'd2
  } state_t;

  localparam int REG_AW_DEF = 5;

  // Counter must hold MD_LAT-1; one extra bit keeps MD_LAT==1 at a legal width.
  function automatic int cnt_width(input int md_lat);
    return $clog2(md_lat) + 1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination (other than r0)
// is read by the instruction currently in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  output logic              hazard
);

  assign hazard = ex_memread
                & (ex_rt != {REG_AW{1'b0}})
                & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: drives PC enable and the en/clr pair of every
// stage register for load-use stalls, taken-branch flushes, multi-cycle
// mult/div stalls and halt/resume.
// Optional feature macro: PIPE_PERF_CNT_EN adds saturating stall/flush counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int MD_LAT = 4
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_br_taken,
  input  logic              ex_md_start,
  input  logic              wb_halt,
  input  logic              resume,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_clr,
  output logic              idex_en,
  output logic              idex_clr,
  output logic              exmem_en,
  output logic              exmem_clr,
  output logic              memwb_en,
  output logic              memwb_clr,
  output logic              halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam int            CW      = cnt_width(MD_LAT);
  localparam logic [CW-1:0] MD_INIT = CW'(MD_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          md_ack_r;
  logic          hazard_s;
  logic          md_stall_s;
  logic          br_fire_s;
  logic          lu_fire_s;

  load_use_detect #(.REG_AW(REG_AW)) u_lud (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .hazard     (hazard_s)
  );

  // md_ack suppresses a restart in the advance cycle right after a stall.
  assign md_stall_s = (state_r == MD_BUSY)
                    | ((state_r == RUN) & ex_md_start & ~md_ack_r);
  assign br_fire_s  = (state_r == RUN) & ~wb_halt & ~md_stall_s & ex_br_taken;
  assign lu_fire_s  = (state_r == RUN) & hazard_s;

  // Stage-register controls, highest-priority rule first.
  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    ifid_clr  = 1'b0;
    idex_en   = 1'b1;
    idex_clr  = 1'b0;
    exmem_en  = 1'b1;
    exmem_clr = 1'b0;
    memwb_en  = 1'b1;
    memwb_clr = 1'b0;
    halted    = rst_n & (state_r == HALTED);
    if (!rst_n) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      ifid_clr  = 1'b1;
      idex_en   = 1'b0;
      idex_clr  = 1'b1;
      exmem_en  = 1'b0;
      exmem_clr = 1'b1;
      memwb_en  = 1'b0;
      memwb_clr = 1'b1;
    end else if (wb_halt || (state_r == HALTED)) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (md_stall_s) begin
      // Hold front end; EX/MEM takes a bubble while older work drains.
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_clr = 1'b1;
    end else if (br_fire_s) begin
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if (lu_fire_s) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_clr = 1'b1;
    end else begin
      pc_en = 1'b1;
    end
  end

  // Control state, mult/div countdown and the one-shot acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= RUN;
      cnt_r    <= {CW{1'b0}};
      md_ack_r <= 1'b0;
    end else if (wb_halt) begin
      state_r  <= HALTED;
      cnt_r    <= {CW{1'b0}};
      md_ack_r <= 1'b0;
    end else begin
      case (state_r)
        HALTED: begin
          if (resume) state_r <= RUN;
          else        state_r <= HALTED;
        end
        MD_BUSY: begin
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r  <= RUN;
            md_ack_r <= 1'b1;
          end else begin
            state_r <= MD_BUSY;
          end
        end
        RUN: begin
          if (md_ack_r) begin
            md_ack_r <= 1'b0;
          end else if (ex_md_start) begin
            if (MD_LAT == 1) begin
              md_ack_r <= 1'b1;
            end else begin
              state_r <= MD_BUSY;
              cnt_r   <= MD_INIT;
            end
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r  <= RUN;
          cnt_r    <= {CW{1'b0}};
          md_ack_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic stall_ev_s;
  assign stall_ev_s = ~pc_en & (state_r != HALTED) & ~wb_halt;

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (stall_ev_s && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(32'd1);
      else                                             stall_cnt <= stall_cnt;
      if (br_fire_s && (flush_cnt != {CNT_W{1'b1}}))  flush_cnt <= flush_cnt + CNT_W'(32'd1);
      else                                             flush_cnt <= flush_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected control vectors are queued as each
// step is driven and compared against the DUT outputs mid-cycle.
// Vector bit order: pc_en ifid_en ifid_clr idex_en idex_clr exmem_en exmem_clr
//                   memwb_en memwb_clr halted
module tb_pipe_ctrl;

  localparam logic [9:0] V_NORM = 10'b1101010100;
  localparam logic [9:0] V_RST  = 10'b0010101010;
  localparam logic [9:0] V_LU   = 10'b0001110100;
  localparam logic [9:0] V_BR   = 10'b1111110100;
  localparam logic [9:0] V_MD   = 10'b0000011100;
  localparam logic [9:0] V_HIN  = 10'b0000000000;
  localparam logic [9:0] V_HLT  = 10'b0000000001;

  typedef struct {
    int         sel;
    logic [9:0] exp;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_memread, ex_br_taken, ex_md_start, wb_halt, resume;
  wire  [9:0] o0, o1;
  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;

`ifdef PIPE_PERF_CNT_EN
  wire [31:0] sc0, fc0, sc1, fc1;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_AW(5), .MD_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken),
    .ex_md_start(ex_md_start), .wb_halt(wb_halt), .resume(resume),
    .pc_en(o0[9]), .ifid_en(o0[8]), .ifid_clr(o0[7]), .idex_en(o0[6]),
    .idex_clr(o0[5]), .exmem_en(o0[4]), .exmem_clr(o0[3]), .memwb_en(o0[2]),
    .memwb_clr(o0[1]), .halted(o0[0])
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(sc0), .flush_cnt(fc0)
`endif
  );

  pipe_ctrl #(.REG_AW(5), .MD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken),
    .ex_md_start(ex_md_start), .wb_halt(wb_halt), .resume(resume),
    .pc_en(o1[9]), .ifid_en(o1[8]), .ifid_clr(o1[7]), .idex_en(o1[6]),
    .idex_clr(o1[5]), .exmem_en(o1[4]), .exmem_clr(o1[3]), .memwb_en(o1[2]),
    .memwb_clr(o1[1]), .halted(o1[0])
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
  );

  task automatic push(input int sel, input logic [9:0] e, input string tag);
    exp_t x;
    x.sel = sel;
    x.exp = e;
    x.tag = tag;
    sb.push_back(x);
  endtask

  // Let combinational outputs settle, then drain the scoreboard.
  task automatic check();
    exp_t       x;
    logic [9:0] obs;
    #2;
    while (sb.size() > 0) begin
      x   = sb.pop_front();
      obs = (x.sel == 1) ? o1 : o0;
      n_cmp++;
      assert (obs === x.exp) else begin
        n_bad++;
        $error("FAIL %s: observed %b expected %b", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic step(input int sel, input logic [9:0] e, input string tag);
    push(sel, e, tag);
    check();
    @(posedge clk);
    #1;
  endtask

  // Drop reset mid-cycle, confirm outputs are forced, release on a negedge.
  task automatic pulse_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    push(0, V_RST, tag);
    push(1, V_RST, {tag, "_md1"});
    check();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    ex_memread = 1'b0; ex_br_taken = 1'b0; ex_md_start = 1'b0;
    wb_halt = 1'b0; resume = 1'b0;
    #1;
    push(0, V_RST, "reset_hold");
    push(1, V_RST, "reset_hold_md1");
    check();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, V_NORM, "idle_run");

    // Load-use hazards
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd1;
    step(0, V_LU, "lu_rs_match");
    ex_rt = 5'd0; id_rs = 5'd0;
    step(0, V_NORM, "lu_r0_ignored");
    ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
    step(0, V_LU, "lu_rt_match");
    id_rt = 5'd6;
    step(0, V_NORM, "lu_no_match");
    ex_memread = 1'b0; id_rt = 5'd7;
    step(0, V_NORM, "lu_not_load");

    // Branch flush outranks load-use
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; ex_br_taken = 1'b1;
    step(0, V_BR, "br_over_lu");
    ex_memread = 1'b0; ex_br_taken = 1'b0;
    step(0, V_NORM, "after_br");

    // Mult/div, MD_LAT=4, start held: 4 stalls, 1 advance, then a new op
    ex_md_start = 1'b1;
    for (int i = 0; i < 4; i++) step(0, V_MD, $sformatf("md4_stall%0d", i));
    step(0, V_NORM, "md4_advance");
    step(0, V_MD, "md4_restart");
    ex_md_start = 1'b0;
    for (int i = 0; i < 3; i++) step(0, V_MD, $sformatf("md4_busy%0d", i));
    step(0, V_NORM, "md4_done");
    ex_br_taken = 1'b1;
    step(0, V_BR, "br_plain");
    ex_br_taken = 1'b0;

    // Mult/div with MD_LAT=1
    pulse_reset("rst_before_md1");
    ex_md_start = 1'b1;
    step(1, V_MD,   "md1_stall");
    step(1, V_NORM, "md1_advance");
    step(1, V_MD,   "md1_restart");
    step(1, V_NORM, "md1_advance2");
    ex_md_start = 1'b0;

    // Halt during MD_BUSY, resume restarts a full stall
    pulse_reset("rst_before_halt");
    ex_md_start = 1'b1;
    step(0, V_MD, "halt_md_c1");
    wb_halt = 1'b1;
    step(0, V_HIN, "halt_in_busy");
    wb_halt = 1'b0;
    step(0, V_HLT, "halted_1");
    ex_br_taken = 1'b1;
    step(0, V_HLT, "halted_ignores_br");
    ex_br_taken = 1'b0; resume = 1'b1;
    step(0, V_HLT, "resume_cycle");
    resume = 1'b0;
    for (int i = 0; i < 4; i++) step(0, V_MD, $sformatf("resume_md%0d", i));
    step(0, V_NORM, "resume_md_advance");
    ex_md_start = 1'b0;
    step(0, V_NORM, "resume_idle");

    // Async reset mid-MD_BUSY
    ex_md_start = 1'b1;
    step(0, V_MD, "rst_md_c1");
    step(0, V_MD, "rst_md_c2");
    ex_md_start = 1'b0;
    pulse_reset("rst_mid_busy");
    step(0, V_NORM, "post_rst_run");
`ifdef PIPE_PERF_CNT_EN
    n_cmp++;
    assert ((sc0 === 32'd0) && (fc0 === 32'd0)) else begin
      n_bad++;
      $error("FAIL perf_zero: observed %0d/%0d expected 0/0", sc0, fc0);
    end
`endif
    ex_md_start = 1'b1;
    for (int i = 0; i < 4; i++) step(0, V_MD, $sformatf("post_rst_md%0d", i));
    step(0, V_NORM, "post_rst_advance");
    ex_md_start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
